// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scanner.
// Segment bytes are active-low and ordered {a,b,c,d,e,f,g,dp}.
// The SEG_x constants are full bytes with the decimal point off.
// hex_glyph() maps a 4-bit digit to the seven active-low segment bits a..g.
package seg_pkg;

    // Bit positions within the 8-bit segment byte
    localparam int unsigned SEG_A_BIT  = 7;
    localparam int unsigned SEG_B_BIT  = 6;
    localparam int unsigned SEG_C_BIT  = 5;
    localparam int unsigned SEG_D_BIT  = 4;
    localparam int unsigned SEG_E_BIT  = 3;
    localparam int unsigned SEG_F_BIT  = 2;
    localparam int unsigned SEG_G_BIT  = 1;
    localparam int unsigned SEG_DP_BIT = 0;

    localparam logic [7:0] SEG_0    = 8'h03;
    localparam logic [7:0] SEG_1    = 8'h9F;
    localparam logic [7:0] SEG_2    = 8'h25;
    localparam logic [7:0] SEG_3    = 8'h0D;
    localparam logic [7:0] SEG_4    = 8'h99;
    localparam logic [7:0] SEG_5    = 8'h49;
    localparam logic [7:0] SEG_6    = 8'h41;
    localparam logic [7:0] SEG_7    = 8'h1F;
    localparam logic [7:0] SEG_8    = 8'h01;
    localparam logic [7:0] SEG_9    = 8'h09;
    localparam logic [7:0] SEG_A    = 8'h11;
    localparam logic [7:0] SEG_B    = 8'hC1;
    localparam logic [7:0] SEG_C    = 8'h63;
    localparam logic [7:0] SEG_D    = 8'h85;
    localparam logic [7:0] SEG_E    = 8'h61;
    localparam logic [7:0] SEG_F    = 8'h71;
    localparam logic [7:0] SEG_DARK = 8'hFF;

    // Active-low a..g pattern for a hex digit (lower-case b and d)
    function automatic logic [6:0] hex_glyph(input logic [3:0] d);
        logic [7:0] b;
        case (d)
            4'h0:    b = SEG_0;
            4'h1:    b = SEG_1;
            4'h2:    b = SEG_2;
            4'h3:    b = SEG_3;
            4'h4:    b = SEG_4;
            4'h5:    b = SEG_5;
            4'h6:    b = SEG_6;
            4'h7:    b = SEG_7;
            4'h8:    b = SEG_8;
            4'h9:    b = SEG_9;
            4'hA:    b = SEG_A;
            4'hB:    b = SEG_B;
            4'hC:    b = SEG_C;
            4'hD:    b = SEG_D;
            4'hE:    b = SEG_E;
            default: b = SEG_F;
        endcase
        return b[SEG_A_BIT:SEG_G_BIT];
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex digit decoder.
// Ports:
//   digit  in  4  hex digit to display
//   dp     in  1  decimal point request (active-high)
//   seg    out 8  active-low {a,b,c,d,e,f,g,dp}
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       dp,
    output logic [7:0] seg
);

    always_comb begin
        seg                        = SEG_DARK;
        seg[SEG_A_BIT:SEG_G_BIT]   = hex_glyph(digit);
        seg[SEG_DP_BIT]            = ~dp;
    end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed seven-segment display driver.
// Holds a shadow copy of NDIG hex digits and scans them one per DIV-cycle slot onto a shared
// active-low segment bus. Each slot begins with GUARD dark cycles to avoid ghosting.
// Ports:
//   clk    in   1       system clock
//   rst_n  in   1       synchronous active-low reset
//   en     in   1       display enable (0 = dark, scanning continues)
//   load   in   1       capture value/dp/blank into the shadow registers
//   value  in   4*NDIG  digit i at value[4i+3:4i], digit 0 rightmost
//   dp     in   NDIG    decimal point per digit
//   blank  in   NDIG    force digit fully dark
//   lzs    in   1       leading-zero suppression, used live
//   seg    out  8       active-low {a,b,c,d,e,f,g,dp}
//   an     out  NDIG    active-low one-hot digit select
//   frame  out  1       pulse on the first output cycle of slot 0
module seg_scan
    import seg_pkg::*;
#(
    parameter int unsigned NDIG  = 8,
    parameter int unsigned DIV   = 50000,
    parameter int unsigned GUARD = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load,
    input  logic [4*NDIG-1:0] value,
    input  logic [NDIG-1:0]   dp,
    input  logic [NDIG-1:0]   blank,
    input  logic              lzs,
    output logic [7:0]        seg,
    output logic [NDIG-1:0]   an,
    output logic              frame
);

    localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned CW = $clog2(DIV);

    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic [4*NDIG-1:0] sh_value;
    logic [NDIG-1:0]   sh_dp;
    logic [NDIG-1:0]   sh_blank;

    logic [3:0]        digit_arr [NDIG];
    logic [NDIG-1:0]   suppress;
    logic [3:0]        cur_digit;
    logic [7:0]        dec_seg;
    logic              in_guard;
    logic              dark;
    logic [7:0]        next_seg;
    logic [NDIG-1:0]   next_an;

    // Prefix-OR from the most significant digit down: a digit is suppressed while no
    // nonzero digit has been seen at or above it. Digit 0 always shows.
    always_comb begin
        logic seen;
        seen = 1'b0;
        for (int i = int'(NDIG) - 1; i >= 0; i--) begin
            digit_arr[i] = sh_value[4*i +: 4];
            seen         = seen | (|digit_arr[i]);
            suppress[i]  = lzs & (i != 0) & ~seen;
        end
    end

    generate
        if (GUARD > 0) begin : g_guard
            assign in_guard = (cnt < CW'(GUARD));
        end else begin : g_no_guard
            assign in_guard = 1'b0;
        end
    endgenerate

    assign cur_digit = digit_arr[idx];
    assign dark      = ~en | in_guard | sh_blank[idx];

    seg_hex_decode u_dec (
        .digit (cur_digit),
        .dp    (sh_dp[idx]),
        .seg   (dec_seg)
    );

    always_comb begin
        next_seg = SEG_DARK;
        next_an  = '1;
        if (!dark) begin
            next_an  = ~(NDIG'(1) << idx);
            next_seg = dec_seg;
            if (suppress[idx]) begin
                // Blank the glyph but keep the decimal point
                next_seg[SEG_A_BIT:SEG_G_BIT] = 7'h7F;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            idx      <= '0;
            sh_value <= '0;
            sh_dp    <= '0;
            sh_blank <= '1;
            seg      <= SEG_DARK;
            an       <= '1;
            frame    <= 1'b0;
        end else begin
            if (cnt == CW'(DIV - 1)) begin
                cnt <= '0;
                idx <= (idx == IW'(NDIG - 1)) ? '0 : idx + IW'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end

            if (load) begin
                sh_value <= value;
                sh_dp    <= dp;
                sh_blank <= blank;
            end

            seg   <= next_seg;
            an    <= next_an;
            frame <= (cnt == '0) && (idx == '0);
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
module tb_seg_scan;

    localparam int NB = 4;
    localparam int DV = 4;
    localparam int GD = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b1;
    logic          load = 1'b0;
    logic [15:0]   value = '0;
    logic [NB-1:0] dp = '0;
    logic [NB-1:0] blank = '0;
    logic          lzs = 1'b0;
    logic [7:0]    seg;
    logic [NB-1:0] an;
    logic          frame;

    int checks = 0;
    int errors = 0;

    seg_scan #(.NDIG(NB), .DIV(DV), .GUARD(GD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .load  (load),
        .value (value),
        .dp    (dp),
        .blank (blank),
        .lzs   (lzs),
        .seg   (seg),
        .an    (an),
        .frame (frame)
    );

    always #5 clk = ~clk;

    // Reference glyph bytes, dp off, written out independently
    logic [7:0] glyph_tab [16];

    // Reference model: t counts non-reset edges since the last reset
    int            t = 0;
    logic [15:0]   m_value = '0;
    logic [NB-1:0] m_dp = '0;
    logic [NB-1:0] m_blank = '1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One clock edge; the model predicts the registered outputs from the pre-edge state
    task automatic step();
        logic [7:0]    es;
        logic [NB-1:0] ea;
        logic          ef;
        logic [7:0]    g;
        logic [3:0]    nib;
        int            c, ix;
        es = 8'hFF;
        ea = '1;
        ef = 1'b0;
        if (rst_n) begin
            c  = t % DV;
            ix = (t / DV) % NB;
            ef = (c == 0) && (ix == 0);
            if (en && c >= GD && !m_blank[ix]) begin
                ea  = ~(NB'(1) << ix);
                nib = 4'(m_value >> (4 * ix));
                g   = glyph_tab[nib];
                if (lzs && ix > 0 && (m_value >> (4 * ix)) == 0) es[7:1] = 7'h7F;
                else es[7:1] = g[7:1];
                es[0] = ~m_dp[ix];
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            t       = 0;
            m_value = '0;
            m_dp    = '0;
            m_blank = '1;
        end else begin
            t++;
            if (load) begin
                m_value = value;
                m_dp    = dp;
                m_blank = blank;
            end
        end
        #1;
        chk("model_seg", 32'(seg), 32'(es));
        chk("model_an", 32'(an), 32'(ea));
        chk("model_frame", 32'(frame), 32'(ef));
    endtask

    // Advance until the next edge will sample slot digit want_idx at prescaler value want_cnt
    task automatic run_until(input int want_idx, input int want_cnt);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 4 * NB * DV; k++) begin
            if ((t % DV) == want_cnt && ((t / DV) % NB) == want_idx) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) chk("run_until_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [NB-1:0] d, input logic [NB-1:0] b);
        value = v;
        dp    = d;
        blank = b;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int k = 0; k < n; k++) step();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [15:0]   value;
        logic [NB-1:0] dp;
        logic [NB-1:0] blank;
        logic          lzs;
        int            digit;
        logic [7:0]    seg;
        logic [NB-1:0] an;
    } vec_t;

    vec_t vecs [18];

    initial begin
        int nfr;
        glyph_tab = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                      8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

        vecs[0]  = '{16'h1F80, 4'b0000, 4'b0000, 1'b0, 0, 8'h03, 4'b1110};
        vecs[1]  = '{16'h1F80, 4'b0000, 4'b0000, 1'b0, 1, 8'h01, 4'b1101};
        vecs[2]  = '{16'h1F80, 4'b0000, 4'b0000, 1'b0, 2, 8'h71, 4'b1011};
        vecs[3]  = '{16'h1F80, 4'b0000, 4'b0000, 1'b0, 3, 8'h9F, 4'b0111};
        vecs[4]  = '{16'h0050, 4'b0000, 4'b0000, 1'b1, 3, 8'hFF, 4'b0111};
        vecs[5]  = '{16'h0050, 4'b0000, 4'b0000, 1'b1, 2, 8'hFF, 4'b1011};
        vecs[6]  = '{16'h0050, 4'b0000, 4'b0000, 1'b1, 1, 8'h49, 4'b1101};
        vecs[7]  = '{16'h0050, 4'b0000, 4'b0000, 1'b1, 0, 8'h03, 4'b1110};
        vecs[8]  = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 3, 8'hFF, 4'b0111};
        vecs[9]  = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 0, 8'h03, 4'b1110};
        vecs[10] = '{16'h0000, 4'b1000, 4'b0000, 1'b1, 3, 8'hFE, 4'b0111};
        vecs[11] = '{16'h8888, 4'b0001, 4'b0100, 1'b0, 0, 8'h00, 4'b1110};
        vecs[12] = '{16'h8888, 4'b0001, 4'b0100, 1'b0, 1, 8'h01, 4'b1101};
        vecs[13] = '{16'h8888, 4'b0001, 4'b0100, 1'b0, 2, 8'hFF, 4'b1111};
        vecs[14] = '{16'h8888, 4'b0001, 4'b0100, 1'b0, 3, 8'h01, 4'b0111};
        vecs[15] = '{16'h2C4A, 4'b0000, 4'b0000, 1'b0, 0, 8'h11, 4'b1110};
        vecs[16] = '{16'h2C4A, 4'b0000, 4'b0000, 1'b0, 2, 8'h63, 4'b1011};
        vecs[17] = '{16'h2C4A, 4'b0000, 4'b0000, 1'b0, 3, 8'h25, 4'b0111};

        // Reset held for 3 cycles: everything dark, no frame
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("reset_seg", 32'(seg), 32'hFF);
            chk("reset_an", 32'(an), 32'hF);
            chk("reset_frame", 32'(frame), 32'h0);
        end
        rst_n = 1'b1;
        // No load yet: every slot stays dark
        for (int k = 0; k < 2 * NB * DV; k++) begin
            step();
            chk("preload_an", 32'(an), 32'hF);
        end

        // Table-driven glyph / LZS / blank / dp checks
        foreach (vecs[i]) begin
            do_reset(1);
            lzs = vecs[i].lzs;
            do_load(vecs[i].value, vecs[i].dp, vecs[i].blank);
            run_until(vecs[i].digit, GD);
            step();
            chk($sformatf("vec%0d_seg", i), 32'(seg), 32'(vecs[i].seg));
            chk($sformatf("vec%0d_an", i), 32'(an), 32'(vecs[i].an));
        end
        lzs = 1'b0;

        // Frame period: 3 pulses in 48 cycles, guard cycle dark
        do_reset(1);
        do_load(16'h1F80, 4'b0000, 4'b0000);
        nfr = 0;
        for (int k = 0; k < 3 * NB * DV; k++) begin
            step();
            if (frame) begin
                nfr++;
                chk("frame_guard_dark", 32'(an), 32'hF);
            end
        end
        chk("frame_count", 32'(nfr), 32'd3);

        // Enable drop in slot 2: dark one edge later, frame keeps pulsing
        do_reset(1);
        do_load(16'h8888, 4'b0000, 4'b0000);
        run_until(2, GD);
        en = 1'b0;
        step();
        chk("en_off_seg", 32'(seg), 32'hFF);
        chk("en_off_an", 32'(an), 32'hF);
        nfr = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (frame) nfr++;
        end
        chk("en_off_frames", 32'(nfr), 32'd1);
        en = 1'b1;
        step();  // samples slot 3, cnt 2
        chk("en_on_an", 32'(an), 32'b0111);
        chk("en_on_seg", 32'(seg), 32'h01);

        // Mid-slot load: seg changes two edges after load, an unchanged
        run_until(0, 1);
        value = 16'h5555;
        load  = 1'b1;
        step();
        load  = 1'b0;
        chk("midload_old_seg", 32'(seg), 32'h01);
        chk("midload_old_an", 32'(an), 32'b1110);
        step();
        chk("midload_new_seg", 32'(seg), 32'h49);
        chk("midload_new_an", 32'(an), 32'b1110);

        // Reset in slot 2: dark afterwards, restart at slot 0, shadow blanked
        run_until(2, 2);
        rst_n = 1'b0;
        step();
        chk("midrst_seg", 32'(seg), 32'hFF);
        chk("midrst_frame", 32'(frame), 32'h0);
        rst_n = 1'b1;
        step();
        chk("midrst_restart_frame", 32'(frame), 32'h1);
        for (int k = 0; k < NB * DV; k++) begin
            step();
            chk("midrst_dark_an", 32'(an), 32'hF);
        end

        // Randomized traffic against the model
        for (int k = 0; k < 800; k++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            en    = ($urandom_range(0, 7) != 0);
            load  = ($urandom_range(0, 5) == 0);
            value = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            dp    = NB'($urandom);
            blank = NB'($urandom) & NB'($urandom);
            lzs   = 1'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
